// File: rtl/mam_bb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mam_bb_arbiter
// Purpose  : Cycle-level req/gnt arbiter sharing one single-port Blackbone
//            memory between the CPU and the MAM debug master. MAM has
//            priority, bounded by a burst limit so the CPU cannot starve.
//            Read data is steered back to whichever master issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module mam_bb_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter bit USE_DEBUG     = 1'b1,
  parameter int MAM_BURST_MAX = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // CPU port
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic          cpu_lock_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_din_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  // MAM port
  input  logic          mam_req_i,
  input  logic          mam_we_i,
  input  logic [AW-1:0] mam_addr_i,
  input  logic [DW-1:0] mam_din_i,
  output logic          mam_gnt_o,
  output logic          mam_rvalid_o,
  output logic [DW-1:0] mam_rdata_o,
  // memory port
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  input  logic [DW-1:0] mem_dout_i,
  // last-cycle owner: 0 idle, 1 MAM, 2 CPU
  output logic [1:0]    owner_o
);

  // Counter must be able to hold MAM_BURST_MAX itself.
  localparam int CW = $clog2(MAM_BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAM_BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAM  = 2'd1,
    ST_CPU  = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  state_t          rd_owner;
  state_t          rd_owner_next;
  logic [CW-1:0]   burst_cnt;
  logic            mam_req_eff;
  logic            win_cpu;
  logic            win_mam;
  logic            burst_full;

  // With the debug port compiled out, MAM requests are simply never seen.
  generate
    if (USE_DEBUG) begin : g_debug
      assign mam_req_eff = mam_req_i;
    end else begin : g_no_debug
      assign mam_req_eff = 1'b0;
    end
  endgenerate

  assign burst_full = (burst_cnt == BURST_LIMIT);

  // Ownership state register; the state is the winner of the previous cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Winner selection in priority order; next state is this cycle's winner.
  always_comb begin
    win_cpu    = 1'b0;
    win_mam    = 1'b0;
    next_state = ST_IDLE;
    if (state == ST_CPU && cpu_lock_i && cpu_req_i) begin
      win_cpu = 1'b1;
    end else if (mam_req_eff && cpu_req_i && burst_full) begin
      win_cpu = 1'b1;
    end else if (mam_req_eff) begin
      win_mam = 1'b1;
    end else if (cpu_req_i) begin
      win_cpu = 1'b1;
    end
    if (win_cpu) begin
      next_state = ST_CPU;
    end else if (win_mam) begin
      next_state = ST_MAM;
    end
  end

  // Grants are masked by reset so nothing reaches the memory while held in reset.
  assign cpu_gnt_o = win_cpu & rst_ni;
  assign mam_gnt_o = win_mam & rst_ni;

  // Memory request mux; every field is zero when nobody is granted.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (cpu_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_we_o   = cpu_we_i;
      mem_addr_o = cpu_addr_i;
      mem_din_o  = cpu_din_i;
    end else if (mam_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_we_o   = mam_we_i;
      mem_addr_o = mam_addr_i;
      mem_din_o  = mam_din_i;
    end
  end

  // Burst counter: counts MAM grants only while the CPU is waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_cnt <= '0;
    end else if (!cpu_req_i || cpu_gnt_o) begin
      burst_cnt <= '0;
    end else if (mam_gnt_o && !burst_full) begin
      burst_cnt <= burst_cnt + CW'(1);
    end
  end

  // Remember who issued the read so the returning data goes to its issuer.
  always_comb begin
    rd_owner_next = ST_IDLE;
    if (cpu_gnt_o && !cpu_we_i) begin
      rd_owner_next = ST_CPU;
    end else if (mam_gnt_o && !mam_we_i) begin
      rd_owner_next = ST_MAM;
    end
  end

  // Read-owner register; reset drops any in-flight read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_owner <= ST_IDLE;
    end else begin
      rd_owner <= rd_owner_next;
    end
  end

  assign cpu_rvalid_o = (rd_owner == ST_CPU) & rst_ni;
  assign mam_rvalid_o = (rd_owner == ST_MAM) & rst_ni;
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_dout_i : '0;
  assign mam_rdata_o  = mam_rvalid_o ? mem_dout_i : '0;
  assign owner_o      = state;

endmodule
`default_nettype wire

// File: tb/tb_mam_bb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mam_bb_arbiter
// Purpose  : Directed self-checking bench for mam_bb_arbiter, with a second
//            instance built without the debug port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mam_bb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_lock;
  logic [31:0] cpu_addr, cpu_din;
  logic        mam_req, mam_we;
  logic [31:0] mam_addr, mam_din;
  logic [31:0] mem_dout;

  logic        cpu_gnt, cpu_rvalid, mam_gnt, mam_rvalid;
  logic [31:0] cpu_rdata, mam_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [1:0]  owner;

  logic        nd_cpu_gnt, nd_cpu_rvalid, nd_mam_gnt, nd_mam_rvalid;
  logic [31:0] nd_cpu_rdata, nd_mam_rdata;
  logic        nd_mem_en, nd_mem_we;
  logic [31:0] nd_mem_addr, nd_mem_din;
  logic [1:0]  nd_owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mam_bb_arbiter #(.AW(32), .DW(32), .USE_DEBUG(1'b1), .MAM_BURST_MAX(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_lock_i(cpu_lock),
    .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .mam_req_i(mam_req), .mam_we_i(mam_we), .mam_addr_i(mam_addr), .mam_din_i(mam_din),
    .mam_gnt_o(mam_gnt), .mam_rvalid_o(mam_rvalid), .mam_rdata_o(mam_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_dout_i(mem_dout), .owner_o(owner)
  );

  mam_bb_arbiter #(.AW(32), .DW(32), .USE_DEBUG(1'b0), .MAM_BURST_MAX(16)) dut_nd (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_lock_i(cpu_lock),
    .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
    .cpu_gnt_o(nd_cpu_gnt), .cpu_rvalid_o(nd_cpu_rvalid), .cpu_rdata_o(nd_cpu_rdata),
    .mam_req_i(mam_req), .mam_we_i(mam_we), .mam_addr_i(mam_addr), .mam_din_i(mam_din),
    .mam_gnt_o(nd_mam_gnt), .mam_rvalid_o(nd_mam_rvalid), .mam_rdata_o(nd_mam_rdata),
    .mem_en_o(nd_mem_en), .mem_we_o(nd_mem_we), .mem_addr_o(nd_mem_addr), .mem_din_o(nd_mem_din),
    .mem_dout_i(32'h0000_5A5A), .owner_o(nd_owner)
  );

  // Read-only memory model with one cycle of read latency.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h10:  rom = 32'h0000_CAFE;
      32'h04:  rom = 32'h1111_0004;
      32'h08:  rom = 32'h2222_0008;
      default: rom = 32'hDEAD_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_dout <= rom(mem_addr);
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_din = '0;
    mam_req = 1'b0; mam_we = 1'b0; mam_addr = '0; mam_din = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    cpu_req = 1'b1;
    mam_req = 1'b1;
    next_cycle();
    #1;
    total++;
    if ({cpu_gnt, mam_gnt, mem_en, mem_we} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_gnt: got %b want 0000", {cpu_gnt, mam_gnt, mem_en, mem_we});
    end
    total++;
    if ({cpu_rvalid, mam_rvalid, owner} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_rv_owner: got %b want 0000", {cpu_rvalid, mam_rvalid, owner});
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    total++;
    if ({cpu_gnt, mam_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL cpu_read_gnt: got gnt/mam/en/we=%b addr=%h want 1010 addr=10",
               {cpu_gnt, mam_gnt, mem_en, mem_we}, mem_addr);
    end
    next_cycle();
    idle_inputs();
    #1;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0000_CAFE || mam_rvalid !== 1'b0 || owner !== 2'd2) begin
      bad++;
      $display("FAIL cpu_read_data: got rv=%b data=%h mrv=%b owner=%0d want 1 0000cafe 0 2",
               cpu_rvalid, cpu_rdata, mam_rvalid, owner);
    end
    next_cycle();
    total++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || owner !== 2'd0) begin
      bad++;
      $display("FAIL cpu_read_after: got rv=%b data=%h owner=%0d want 0 0 0", cpu_rvalid, cpu_rdata, owner);
    end
  endtask

  task automatic test_burst();
    int errs = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_din = 32'hC0;
    mam_req = 1'b1; mam_we = 1'b1; mam_addr = 32'h44; mam_din = 32'hA0;
    for (int i = 0; i < 20; i++) begin
      logic exp_cpu;
      exp_cpu = (i == 16);
      #1;
      if (cpu_gnt !== exp_cpu || mam_gnt !== !exp_cpu) begin
        errs++;
        $display("FAIL burst_cycle%0d: got cpu=%b mam=%b want cpu=%b mam=%b",
                 i, cpu_gnt, mam_gnt, exp_cpu, !exp_cpu);
      end
      next_cycle();
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (dut.burst_cnt !== 5'd3) begin
      bad++;
      $display("FAIL burst_cnt_resume: got %0d want 3", dut.burst_cnt);
    end
    cpu_req = 1'b0;
    next_cycle();
    total++;
    if (dut.burst_cnt !== 5'd0) begin
      bad++;
      $display("FAIL burst_cnt_clear: got %0d want 0", dut.burst_cnt);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_lock();
    int errs = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_lock = 1'b1; cpu_addr = 32'h50;
    #1;
    total++;
    if (cpu_gnt !== 1'b1 || mam_gnt !== 1'b0) begin
      bad++;
      $display("FAIL lock_first: got cpu=%b mam=%b want 1 0", cpu_gnt, mam_gnt);
    end
    next_cycle();
    mam_req = 1'b1; mam_we = 1'b1; mam_addr = 32'h54;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (cpu_gnt !== 1'b1 || mam_gnt !== 1'b0) begin
        errs++;
        $display("FAIL lock_hold%0d: got cpu=%b mam=%b want 1 0", i, cpu_gnt, mam_gnt);
      end
      next_cycle();
    end
    total++;
    if (errs != 0) bad++;
    cpu_lock = 1'b0;
    #1;
    total++;
    if (cpu_gnt !== 1'b0 || mam_gnt !== 1'b1) begin
      bad++;
      $display("FAIL lock_release: got cpu=%b mam=%b want 0 1", cpu_gnt, mam_gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    mam_req = 1'b1; mam_we = 1'b0; mam_addr = 32'h04;
    #1;
    total++;
    if (mam_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_addr !== 32'h04) begin
      bad++;
      $display("FAIL b2b_mam_gnt: got mam=%b cpu=%b addr=%h want 1 0 04", mam_gnt, cpu_gnt, mem_addr);
    end
    next_cycle();
    mam_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
    #1;
    total++;
    if (cpu_gnt !== 1'b1 || mam_rvalid !== 1'b1 || mam_rdata !== 32'h1111_0004 ||
        cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL b2b_mam_data: got cgnt=%b mrv=%b mdata=%h crv=%b cdata=%h want 1 1 11110004 0 0",
               cpu_gnt, mam_rvalid, mam_rdata, cpu_rvalid, cpu_rdata);
    end
    next_cycle();
    idle_inputs();
    #1;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h2222_0008 || mam_rvalid !== 1'b0 || mam_rdata !== 32'h0) begin
      bad++;
      $display("FAIL b2b_cpu_data: got crv=%b cdata=%h mrv=%b mdata=%h want 1 22220008 0 0",
               cpu_rvalid, cpu_rdata, mam_rvalid, mam_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    mam_req = 1'b1; mam_we = 1'b0; mam_addr = 32'h04;
    #1;
    total++;
    if (mam_gnt !== 1'b1) begin
      bad++;
      $display("FAIL inflight_gnt: got %b want 1", mam_gnt);
    end
    next_cycle();
    rst_n = 1'b0;
    cpu_req = 1'b1;
    #1;
    total++;
    if ({cpu_gnt, mam_gnt, mem_en, mem_we, cpu_rvalid, mam_rvalid, owner} !== 8'h00) begin
      bad++;
      $display("FAIL inflight_during: got %b want 00000000",
               {cpu_gnt, mam_gnt, mem_en, mem_we, cpu_rvalid, mam_rvalid, owner});
    end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    total++;
    if ({mam_rvalid, cpu_rvalid, mem_en, owner} !== 5'b00000 || mam_rdata !== 32'h0) begin
      bad++;
      $display("FAIL inflight_after: got rv/en/owner=%b mdata=%h want 00000 0",
               {mam_rvalid, cpu_rvalid, mem_en, owner}, mam_rdata);
    end
    next_cycle();
    total++;
    if (mam_rvalid !== 1'b0 || owner !== 2'd0) begin
      bad++;
      $display("FAIL inflight_after2: got mrv=%b owner=%0d want 0 0", mam_rvalid, owner);
    end
  endtask

  task automatic test_no_debug();
    int errs = 0;
    mam_req = 1'b1; mam_we = 1'b0; mam_addr = 32'h04;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (nd_cpu_gnt !== 1'b1 || nd_mam_gnt !== 1'b0 || nd_mam_rvalid !== 1'b0) begin
        errs++;
        $display("FAIL nodebug_cycle%0d: got cpu=%b mam=%b mrv=%b want 1 0 0",
                 i, nd_cpu_gnt, nd_mam_gnt, nd_mam_rvalid);
      end
      next_cycle();
    end
    total++;
    if (errs != 0) bad++;
    cpu_req = 1'b0;
    #1;
    total++;
    if (nd_cpu_rvalid !== 1'b1 || nd_cpu_rdata !== 32'h0000_5A5A) begin
      bad++;
      $display("FAIL nodebug_rdata: got rv=%b data=%h want 1 00005a5a", nd_cpu_rvalid, nd_cpu_rdata);
    end
    total++;
    if (nd_mam_gnt !== 1'b0 || nd_mem_en !== 1'b0) begin
      bad++;
      $display("FAIL nodebug_mam_only: got mgnt=%b en=%b want 0 0", nd_mam_gnt, nd_mem_en);
    end
    next_cycle();
    total++;
    if (nd_mam_rvalid !== 1'b0 || nd_mam_rdata !== 32'h0 || nd_owner !== 2'd0) begin
      bad++;
      $display("FAIL nodebug_idle: got mrv=%b mdata=%h owner=%0d want 0 0 0",
               nd_mam_rvalid, nd_mam_rdata, nd_owner);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    mem_dout = '0;
    test_reset();
    test_cpu_read();
    test_burst();
    test_lock();
    test_back_to_back();
    test_reset_inflight();
    test_no_debug();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
